// File: rtl/addr_decoder_rr.sv
// addr_decoder_rr
//   Decodes host ops to NUM_SW_INST switch channels and queues each op in a
//   small per-channel FIFO. The FIFOs drain onto one shared switch bus under a
//   round-robin arbiter. Each op gets exactly one response: read data, a write
//   completion, or an error when the address hits no switch or the switch does
//   not ack within TIMEOUT_CYC cycles.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   en_in           intake enable; queued and in-flight ops finish regardless
//   valid_in        host op valid; accepted on an edge where ready_out is high
//   wr_rd_op        1 = write, 0 = read
//   addr_in         op address; switch index = addr_in >> SW_ADDR_BITS
//   op_id_in        op tag, returned on done_op_id
//   wr_data_in      write data
//   ready_out       intake ready
//   rsp_valid_out   one-cycle response strobe
//   rsp_err_out     response is an error (decode miss or timeout)
//   rd_data_out     read data (0 for writes and errors)
//   done_op_id      tag of the completed op
//   sel_en_out      one-hot switch select, held until ack or timeout
//   wr_rd_s_out     op type to switch
//   addr_out        full op address to switch
//   wr_data_out     write data to switch
//   rd_data_in      read data from the selected switch, sampled with its ack
//   ack_in          per-switch completion
module addr_decoder_rr #(
  parameter int NUM_SW_INST  = 5,
  parameter int W_WIDTH      = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int SW_ADDR_BITS = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int OP_ID_WIDTH  = 8,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic                   valid_in,
  input  logic                   wr_rd_op,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic [OP_ID_WIDTH-1:0] op_id_in,
  input  logic [W_WIDTH-1:0]     wr_data_in,
  output logic                   ready_out,
  output logic                   rsp_valid_out,
  output logic                   rsp_err_out,
  output logic [W_WIDTH-1:0]     rd_data_out,
  output logic [OP_ID_WIDTH-1:0] done_op_id,
  output logic [NUM_SW_INST-1:0] sel_en_out,
  output logic                   wr_rd_s_out,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [W_WIDTH-1:0]     wr_data_out,
  input  logic [W_WIDTH-1:0]     rd_data_in,
  input  logic [NUM_SW_INST-1:0] ack_in
);

  localparam int FW = 1 + ADDR_WIDTH + OP_ID_WIDTH + W_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 2);
  // Timer value seen on the edge that ends the TIMEOUT_CYC-th select cycle.
  localparam logic [TW-1:0] TMR_LAST = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]             dec_idx;
  logic                              dec_hit;
  logic                              accept;
  logic [FW-1:0]                     frame_in;
  logic [NUM_SW_INST-1:0]            full, empty, push, pop;
  logic [NUM_SW_INST-1:0][FW-1:0]    head_all;
  logic [FW-1:0]                     head;

  logic                              err_pend;
  logic [OP_ID_WIDTH-1:0]            err_id;
  logic                              err_emit;

  logic [IW-1:0]                     rr_ptr, cur_g, gnt_idx;
  logic                              gnt_found, grant, ack_hit, tmo;
  logic [TW-1:0]                     timer;
  logic [OP_ID_WIDTH-1:0]            cur_id;
  logic [W_WIDTH-1:0]                rsp_data;
  logic                              rsp_err;

  // ---- intake and decode ----
  assign dec_idx   = addr_in >> SW_ADDR_BITS;
  assign dec_hit   = (dec_idx < ADDR_WIDTH'(NUM_SW_INST));
  assign ready_out = en_in & ~(|full) & ~err_pend;
  assign accept    = valid_in & ready_out;
  assign frame_in  = {wr_rd_op, addr_in, op_id_in, wr_data_in};

  // ---- per-channel FIFOs ----
  for (genvar c = 0; c < NUM_SW_INST; c++) begin : g_ch
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   cnt;

    assign full[c]     = (cnt == (PW+1)'(FIFO_DEPTH));
    assign empty[c]    = (cnt == '0);
    assign push[c]     = accept & dec_hit & (dec_idx == ADDR_WIDTH'(c));
    assign pop[c]      = grant & (gnt_idx == IW'(c));
    assign head_all[c] = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[c])  rd_ptr <= rd_ptr + 1'b1;
        // Simultaneous push and pop leaves occupancy unchanged.
        if (push[c] && !pop[c])      cnt <= cnt + 1'b1;
        else if (pop[c] && !push[c]) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push[c]) mem[wr_ptr] <= frame_in;
    end
  end

  assign head = head_all[gnt_idx];

  // ---- round-robin pick: first non-empty channel after rr_ptr, wrapping ----
  always_comb begin
    logic [IW-1:0] cand;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NUM_SW_INST; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NUM_SW_INST);
      if (!gnt_found && !empty[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // ---- bus FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_hit   = 1'b0;
    tmo       = 1'b0;
    case (state)
      // A fresh grant may be issued on the edge that leaves RESP.
      IDLE, RESP: begin
        if (gnt_found) begin
          grant     = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (ack_in[cur_g]) begin
          ack_hit   = 1'b1;
          state_nxt = RESP;
        end else if (TIMEOUT_CYC != 0 && timer == TMR_LAST) begin
          tmo       = 1'b1;
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completion in RESP owns the response port; a decode miss waits behind it.
  assign err_emit = err_pend & (state != RESP);

  // ---- bus drive and completion capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_en_out  <= '0;
      wr_rd_s_out <= 1'b0;
      addr_out    <= '0;
      wr_data_out <= '0;
      cur_id      <= '0;
      cur_g       <= '0;
      rr_ptr      <= IW'(NUM_SW_INST - 1);
      timer       <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      err_pend    <= 1'b0;
      err_id      <= '0;
    end else begin
      if (grant) begin
        sel_en_out <= NUM_SW_INST'(1) << gnt_idx;
        {wr_rd_s_out, addr_out, cur_id, wr_data_out} <= head;
        cur_g      <= gnt_idx;
        rr_ptr     <= gnt_idx;
        timer      <= '0;
      end else if (state == BUSY) begin
        timer <= timer + 1'b1;
        if (ack_hit) begin
          sel_en_out <= '0;
          rsp_data   <= wr_rd_s_out ? '0 : rd_data_in;
          rsp_err    <= 1'b0;
        end else if (tmo) begin
          sel_en_out <= '0;
          rsp_data   <= '0;
          rsp_err    <= 1'b1;
        end
      end

      // Intake is blocked while err_pend is set, so set and clear never collide.
      if (accept && !dec_hit) begin
        err_pend <= 1'b1;
        err_id   <= op_id_in;
      end else if (err_emit) begin
        err_pend <= 1'b0;
      end
    end
  end

  // ---- response port ----
  always_comb begin
    rsp_valid_out = 1'b0;
    rsp_err_out   = 1'b0;
    rd_data_out   = '0;
    done_op_id    = '0;
    if (state == RESP) begin
      rsp_valid_out = 1'b1;
      rsp_err_out   = rsp_err;
      rd_data_out   = rsp_data;
      done_op_id    = cur_id;
    end else if (err_emit) begin
      rsp_valid_out = 1'b1;
      rsp_err_out   = 1'b1;
      done_op_id    = err_id;
    end
  end

endmodule

// File: tb/tb_addr_decoder_rr.sv
// Self-checking bench for addr_decoder_rr: a scoreboard of expected responses
// is filled as ops are driven and checked against responses collected by a
// monitor; a behavioural switch model acks with per-switch delay and data.
module tb_addr_decoder_rr;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en_in = 1'b0;
  logic         valid_in = 1'b0;
  logic         wr_rd_op = 1'b0;
  logic [7:0]   addr_in = '0;
  logic [7:0]   op_id_in = '0;
  logic [7:0]   wr_data_in = '0;
  logic         ready_out;
  logic         rsp_valid_out;
  logic         rsp_err_out;
  logic [7:0]   rd_data_out;
  logic [7:0]   done_op_id;
  logic [N-1:0] sel_en_out;
  logic         wr_rd_s_out;
  logic [7:0]   addr_out;
  logic [7:0]   wr_data_out;
  logic [7:0]   rd_data_in;
  logic [N-1:0] ack_in;

  addr_decoder_rr dut (
    .clk(clk), .rst(rst), .en_in(en_in), .valid_in(valid_in),
    .wr_rd_op(wr_rd_op), .addr_in(addr_in), .op_id_in(op_id_in),
    .wr_data_in(wr_data_in), .ready_out(ready_out),
    .rsp_valid_out(rsp_valid_out), .rsp_err_out(rsp_err_out),
    .rd_data_out(rd_data_out), .done_op_id(done_op_id),
    .sel_en_out(sel_en_out), .wr_rd_s_out(wr_rd_s_out), .addr_out(addr_out),
    .wr_data_out(wr_data_out), .rd_data_in(rd_data_in), .ack_in(ack_in)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // response = {id, err, data}
  logic [16:0] exp_q[$];
  logic [16:0] obs_rsp[$];
  logic [N-1:0] obs_sel[$];
  int           obs_hold[$];

  int   sw_delay [N] = '{2, 2, 3, 2, 2};
  bit   sw_dead  [N] = '{0, 0, 0, 0, 0};
  logic [7:0] sw_rdata [N] = '{8'h10, 8'h11, 8'hA5, 8'h33, 8'h14};

  // Monitor: collect responses, select rises and select hold lengths.
  logic [N-1:0] prev_sel = '0;
  int           hold = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_sel = '0;
      hold = 0;
    end else begin
      if (rsp_valid_out) obs_rsp.push_back({done_op_id, rsp_err_out, rd_data_out});
      if (sel_en_out != '0 && prev_sel == '0) obs_sel.push_back(sel_en_out);
      if (sel_en_out != '0) hold++;
      else if (prev_sel != '0) begin
        obs_hold.push_back(hold);
        hold = 0;
      end
      prev_sel = sel_en_out;
    end
  end

  // Switch model: ack the selected switch after sw_delay negedges of select.
  initial begin
    int rcnt;
    int g;
    rcnt = 0;
    ack_in = '0;
    rd_data_in = '0;
    forever begin
      @(negedge clk);
      if (rst || ack_in != '0) begin
        ack_in = '0;
        rd_data_in = '0;
        rcnt = 0;
      end else if (sel_en_out != '0) begin
        g = 0;
        for (int k = 0; k < N; k++) if (sel_en_out[k]) g = k;
        if (!sw_dead[g]) begin
          rcnt++;
          if (rcnt >= sw_delay[g]) begin
            ack_in[g] = 1'b1;
            rd_data_in = sw_rdata[g];
            rcnt = 0;
          end
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the
  // accepting edge with valid_in still high.
  task automatic send_op(input logic wr, input logic [7:0] addr,
                         input logic [7:0] id, input logic [7:0] data);
    bit done;
    done = 1'b0;
    wr_rd_op = wr; addr_in = addr; op_id_in = id; wr_data_in = data;
    valid_in = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (ready_out) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL intake_timeout: op id %0d accepted=0, required accepted=1", id);
      valid_in = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_rsp.delete();
    obs_sel.delete();
    obs_hold.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_in = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (sel_en_out !== '0) begin
      miscompares++;
      $display("FAIL reset_sel: got %b, required 0", sel_en_out);
    end
    vectors++;
    if ({rsp_valid_out, rsp_err_out, rd_data_out, done_op_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: got v=%b e=%b d=%h id=%h, required all 0",
               rsp_valid_out, rsp_err_out, rd_data_out, done_op_id);
    end
    vectors++;
    if ({wr_rd_s_out, addr_out, wr_data_out, ready_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got wr=%b a=%h d=%h rdy=%b, required all 0",
               wr_rd_s_out, addr_out, wr_data_out, ready_out);
    end
    rst = 1'b0;
    @(negedge clk);
    en_in = 1'b1;
    #1;
    vectors++;
    if (ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 1", ready_out);
    end
  endtask

  task automatic test_single_read();
    clear_obs();
    send_op(1'b0, 8'h23, 8'd7, 8'h00);
    valid_in = 1'b0;
    exp_q.push_back({8'd7, 1'b0, 8'hA5});
    vectors++;
    if (sel_en_out !== 5'b00000) begin
      miscompares++;
      $display("FAIL single_sel_early: got %b, required 00000", sel_en_out);
    end
    @(negedge clk);
    vectors++;
    if (sel_en_out !== 5'b00100 || addr_out !== 8'h23 || wr_rd_s_out !== 1'b0) begin
      miscompares++;
      $display("FAIL single_bus: got sel=%b addr=%h wr=%b, required 00100 23 0",
               sel_en_out, addr_out, wr_rd_s_out);
    end
    for (int i = 0; i < 100 && obs_rsp.size() < exp_q.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_rsp.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_rsp_count: got %0d, required %0d", obs_rsp.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rsp.size() > 0) begin
      logic [16:0] got, want;
      got = obs_rsp.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL single_rsp: got id=%0d err=%b data=%h, required id=%0d err=%b data=%h",
                 got[16:9], got[8], got[7:0], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_sel [4];
    exp_sel = '{5'b00001, 5'b00010, 5'b10000, 5'b00001};
    clear_obs();
    send_op(1'b0, 8'h05, 8'd20, 8'h00); exp_q.push_back({8'd20, 1'b0, 8'h10});
    send_op(1'b0, 8'h15, 8'd21, 8'h00); exp_q.push_back({8'd21, 1'b0, 8'h11});
    send_op(1'b1, 8'h45, 8'd22, 8'h3C); exp_q.push_back({8'd22, 1'b0, 8'h00});
    send_op(1'b0, 8'h07, 8'd23, 8'h00); exp_q.push_back({8'd23, 1'b0, 8'h10});
    valid_in = 1'b0;
    for (int i = 0; i < 200 && obs_rsp.size() < exp_q.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= obs_sel.size() || obs_sel[i] !== exp_sel[i]) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %b, required %b", i,
                 (i < obs_sel.size()) ? obs_sel[i] : 5'b0, exp_sel[i]);
      end
    end
    vectors++;
    if (obs_rsp.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_rsp_count: got %0d, required %0d", obs_rsp.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rsp.size() > 0) begin
      logic [16:0] got, want;
      got = obs_rsp.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b_rsp: got id=%0d err=%b data=%h, required id=%0d err=%b data=%h",
                 got[16:9], got[8], got[7:0], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_decode_miss();
    clear_obs();
    send_op(1'b0, 8'h70, 8'd9, 8'h00);
    valid_in = 1'b0;
    exp_q.push_back({8'd9, 1'b1, 8'h00});
    vectors++;
    if (ready_out !== 1'b0 || rsp_valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_pending: got ready=%b rsp_valid=%b, required 0 1",
               ready_out, rsp_valid_out);
    end
    @(negedge clk);
    vectors++;
    if (ready_out !== 1'b1 || rsp_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_release: got ready=%b rsp_valid=%b, required 1 0",
               ready_out, rsp_valid_out);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_sel.size() != 0 || obs_rsp.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL miss_counts: got sel=%0d rsp=%0d, required 0 %0d",
               obs_sel.size(), obs_rsp.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rsp.size() > 0) begin
      logic [16:0] got, want;
      got = obs_rsp.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL miss_rsp: got id=%0d err=%b data=%h, required id=%0d err=%b data=%h",
                 got[16:9], got[8], got[7:0], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    sw_dead[3] = 1'b1;
    send_op(1'b0, 8'h31, 8'd30, 8'h00); exp_q.push_back({8'd30, 1'b1, 8'h00});
    send_op(1'b0, 8'h02, 8'd31, 8'h00); exp_q.push_back({8'd31, 1'b0, 8'h10});
    valid_in = 1'b0;
    for (int i = 0; i < 200 && obs_rsp.size() < exp_q.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_hold.size() < 1 || obs_hold[0] != 16) begin
      miscompares++;
      $display("FAIL timeout_hold: got %0d cycles, required 16",
               (obs_hold.size() > 0) ? obs_hold[0] : -1);
    end
    vectors++;
    if (obs_sel.size() != 2 || obs_sel[0] !== 5'b01000 || obs_sel[1] !== 5'b00001) begin
      miscompares++;
      $display("FAIL timeout_order: got %0d grants first=%b, required 2 grants 01000 then 00001",
               obs_sel.size(), (obs_sel.size() > 0) ? obs_sel[0] : 5'b0);
    end
    while (exp_q.size() > 0 && obs_rsp.size() > 0) begin
      logic [16:0] got, want;
      got = obs_rsp.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL timeout_rsp: got id=%0d err=%b data=%h, required id=%0d err=%b data=%h",
                 got[16:9], got[8], got[7:0], want[16:9], want[8], want[7:0]);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_rsp_count: got %0d missing, required 0", exp_q.size());
    end
    sw_dead[3] = 1'b0;
  endtask

  task automatic test_fifo_full();
    clear_obs();
    sw_delay[1] = 10;
    send_op(1'b0, 8'h12, 8'd40, 8'h00); exp_q.push_back({8'd40, 1'b0, 8'h11});
    send_op(1'b0, 8'h13, 8'd41, 8'h00); exp_q.push_back({8'd41, 1'b0, 8'h11});
    send_op(1'b0, 8'h14, 8'd42, 8'h00); exp_q.push_back({8'd42, 1'b0, 8'h11});
    // Fourth op held on valid_in while FIFO[1] is full.
    wr_rd_op = 1'b0; addr_in = 8'h15; op_id_in = 8'd43;
    exp_q.push_back({8'd43, 1'b0, 8'h11});
    #1;
    vectors++;
    if (ready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got %b, required 0", ready_out);
    end
    for (int i = 0; i < 200 && ready_out !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    vectors++;
    if (ready_out !== 1'b1 || sel_en_out !== 5'b00010 || addr_out !== 8'h13) begin
      miscompares++;
      $display("FAIL full_release: got ready=%b sel=%b addr=%h, required 1 00010 13",
               ready_out, sel_en_out, addr_out);
    end
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < 300 && obs_rsp.size() < exp_q.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_rsp.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL full_rsp_count: got %0d, required %0d", obs_rsp.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rsp.size() > 0) begin
      logic [16:0] got, want;
      got = obs_rsp.pop_front();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL full_rsp: got id=%0d err=%b data=%h, required id=%0d err=%b data=%h",
                 got[16:9], got[8], got[7:0], want[16:9], want[8], want[7:0]);
      end
    end
    sw_delay[1] = 2;
  endtask

  task automatic test_enable();
    clear_obs();
    en_in = 1'b0;
    wr_rd_op = 1'b1; addr_in = 8'h01; op_id_in = 8'd60; wr_data_in = 8'h5A;
    valid_in = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (ready_out !== 1'b0 || obs_sel.size() != 0) begin
      miscompares++;
      $display("FAIL enable_block: got ready=%b grants=%0d, required 0 0", ready_out, obs_sel.size());
    end
    en_in = 1'b1;
    send_op(1'b1, 8'h01, 8'd60, 8'h5A);
    valid_in = 1'b0;
    exp_q.push_back({8'd60, 1'b0, 8'h00});
    en_in = 1'b0;
    for (int i = 0; i < 100 && obs_rsp.size() < exp_q.size(); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_rsp.size() != 1 || obs_rsp[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL enable_inflight: got %0d rsp first=%h, required 1 rsp %h",
               obs_rsp.size(), (obs_rsp.size() > 0) ? obs_rsp[0] : 17'h0, exp_q[0]);
    end
    en_in = 1'b1;
  endtask

  task automatic test_reset_busy();
    clear_obs();
    sw_dead[3] = 1'b1;
    send_op(1'b0, 8'h30, 8'd50, 8'h00);
    send_op(1'b0, 8'h33, 8'd51, 8'h00);
    valid_in = 1'b0;
    for (int i = 0; i < 20 && sel_en_out !== 5'b01000; i++) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (sel_en_out !== 5'b00000 || rsp_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got sel=%b rsp_valid=%b, required 00000 0", sel_en_out, rsp_valid_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (30) @(negedge clk);
    vectors++;
    if (obs_rsp.size() != 0 || obs_sel.size() != 0) begin
      miscompares++;
      $display("FAIL rst_stale: got rsp=%0d grants=%0d, required 0 0", obs_rsp.size(), obs_sel.size());
    end
    sw_dead[3] = 1'b0;
    sw_delay[3] = 1;
    send_op(1'b0, 8'h3F, 8'd52, 8'h00);
    valid_in = 1'b0;
    exp_q.push_back({8'd52, 1'b0, 8'h33});
    for (int i = 0; i < 100 && obs_rsp.size() < exp_q.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_sel.size() != 1 || obs_sel[0] !== 5'b01000 || obs_rsp.size() != 1 || obs_rsp[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL rst_after: got grants=%0d rsp=%0d first=%h, required 1 grant 01000 and rsp %h",
               obs_sel.size(), obs_rsp.size(), (obs_rsp.size() > 0) ? obs_rsp[0] : 17'h0, exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_decode_miss();
    test_timeout();
    test_fifo_full();
    test_enable();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
